// File: rtl/spart_pkg.sv
// Shared SPART definitions: transmitter FSM states and the frame/timing constants
// used by the transmitter, receiver and baud generator.
package spart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_t;

    localparam int unsigned SPART_OVERSAMPLE    = 16;
    localparam int unsigned SPART_DATA_BITS     = 8;
    localparam int unsigned SPART_TX_FIFO_DEPTH = 4;

endpackage

// File: rtl/spart_tx_if.sv
// Bus-interface side of the SPART transmitter: write strobe, data byte and
// the transmit-buffer-ready status returned to the status register.
import spart_pkg::*;

interface spart_tx_if #(
    parameter int unsigned DATA_BITS = SPART_DATA_BITS
) ();
    logic                 wrt_tx;
    logic [DATA_BITS-1:0] data_in;
    logic                 tbr;

    modport master (output wrt_tx, output data_in, input tbr);
    modport slave  (input wrt_tx, input data_in, output tbr);
endinterface

// File: rtl/spart_tx_fifo.sv
// Synchronous first-word-fall-through FIFO holding bytes awaiting transmission.
// Pushes while full and pops while empty are ignored; DEPTH must be a power of two.
module spart_tx_fifo #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;
    assign dout    = mem[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok)
                rd_ptr <= rd_ptr + 1'b1;
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok)
            mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/spart_tx.sv
// SPART transmitter: queues bus writes and serialises them LSB first as 8N1 on txd.
// Define SPART_TX_PARITY_EN to insert an even-parity bit before the stop bit (8E1).
import spart_pkg::*;

module spart_tx #(
    parameter int unsigned FIFO_DEPTH = SPART_TX_FIFO_DEPTH,
    parameter int unsigned OVERSAMPLE = SPART_OVERSAMPLE,
    parameter int unsigned DATA_BITS  = SPART_DATA_BITS
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        enable,
    spart_tx_if.slave   bus,
    output logic        txd
);
    localparam int unsigned TW = $clog2(OVERSAMPLE);
    localparam int unsigned BW = $clog2(DATA_BITS);
    localparam int unsigned CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    tx_state_t            state;
    tx_state_t            state_nxt;
    logic [TW-1:0]        tick_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift;
    logic                 txd_nxt;
    logic                 pop;
    logic                 bit_done;

    logic [DATA_BITS-1:0] fifo_dout;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic [CW-1:0]        fifo_count;

`ifdef SPART_TX_PARITY_EN
    logic                 parity_bit;
`endif

    spart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (DATA_BITS)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (bus.wrt_tx && !fifo_full),
        .pop   (pop),
        .din   (bus.data_in),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign bus.tbr  = (fifo_count != CW'(FIFO_DEPTH));
    assign bit_done = enable && (tick_cnt == TICK_LAST);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    // txd_nxt is decoded from the current state and registered, so the line
    // trails the state by one clk but every bit keeps its full length.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        txd_nxt   = 1'b1;
        case (state)
            IDLE: begin
                txd_nxt = 1'b1;
                if (!fifo_empty) begin
                    pop       = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                txd_nxt = 1'b0;
                if (bit_done)
                    state_nxt = DATA;
            end
            DATA: begin
                txd_nxt = shift[0];
                if (bit_done && (bit_cnt == BIT_LAST)) begin
`ifdef SPART_TX_PARITY_EN
                    state_nxt = PARITY;
`else
                    state_nxt = STOP;
`endif
                end
            end
`ifdef SPART_TX_PARITY_EN
            PARITY: begin
                txd_nxt = parity_bit;
                if (bit_done)
                    state_nxt = STOP;
            end
`endif
            STOP: begin
                txd_nxt = 1'b1;
                if (bit_done)
                    state_nxt = IDLE;
            end
            default: begin
                txd_nxt   = 1'b1;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_cnt <= '0;
            bit_cnt  <= '0;
            shift    <= '0;
            txd      <= 1'b1;
        end else begin
            txd <= txd_nxt;
            if (pop) begin
                shift    <= fifo_dout;
                tick_cnt <= '0;
                bit_cnt  <= '0;
            end else if (state != IDLE && enable) begin
                tick_cnt <= bit_done ? '0 : tick_cnt + 1'b1;
                if (state == DATA && bit_done) begin
                    shift   <= shift >> 1;
                    bit_cnt <= bit_cnt + 1'b1;
                end
            end
        end
    end

`ifdef SPART_TX_PARITY_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            parity_bit <= 1'b0;
        else if (pop)
            parity_bit <= ^fifo_dout;
    end
`endif

endmodule

// File: tb/tb_spart_tx.sv
// Self-checking bench for spart_tx: a frame-level model predicts txd/tbr every
// clk, with directed scenarios and literal spot checks on hand-computed timings.
module tb_spart_tx;
    localparam int DEPTH = 4;
    localparam int OVS   = 16;

    logic clk = 1'b0;
    logic rst;
    logic enable;
    logic txd;

    spart_tx_if bus ();

    spart_tx #(
        .FIFO_DEPTH (DEPTH),
        .OVERSAMPLE (OVS),
        .DATA_BITS  (8)
    ) dut (
        .clk    (clk),
        .rst    (rst),
        .enable (enable),
        .bus    (bus),
        .txd    (txd)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %0d, expected %0d", name, $time, act, exp);
        end
    endtask

    // Frame-level model: a byte queue plus the bit list of the frame on the wire.
    logic [7:0] m_q[$];
    logic       m_bits [0:10];
    int         m_nbits;
    int         m_idx;
    int         m_ticks;
    bit         m_active;
    logic       exp_txd;
    logic       exp_tbr;

    task automatic m_reset();
        m_q.delete();
        m_active = 1'b0;
        m_idx    = 0;
        m_ticks  = 0;
        exp_txd  = 1'b1;
        exp_tbr  = 1'b1;
    endtask

    task automatic m_load(input logic [7:0] b);
        m_bits[0] = 1'b0;
        for (int i = 0; i < 8; i++)
            m_bits[1+i] = b[i];
`ifdef SPART_TX_PARITY_EN
        m_bits[9]  = ^b;
        m_bits[10] = 1'b1;
        m_nbits    = 11;
`else
        m_bits[9]  = 1'b1;
        m_nbits    = 10;
`endif
    endtask

    task automatic m_step();
        int size0;
        size0   = m_q.size();
        exp_txd = m_active ? m_bits[m_idx] : 1'b1;
        if (!m_active) begin
            if (size0 > 0) begin
                m_load(m_q.pop_front());
                m_active = 1'b1;
                m_idx    = 0;
                m_ticks  = 0;
            end
        end else if (enable) begin
            m_ticks++;
            if (m_ticks == OVS) begin
                m_ticks = 0;
                m_idx++;
                if (m_idx == m_nbits)
                    m_active = 1'b0;
            end
        end
        if (bus.wrt_tx && size0 != DEPTH)
            m_q.push_back(bus.data_in);
        exp_tbr = (m_q.size() != DEPTH);
    endtask

    initial begin
        m_reset();
        forever begin
            @(posedge clk or posedge rst);
            if (rst)
                m_reset();
            else
                m_step();
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (chk_en) begin
                check("txd", txd, exp_txd);
                check("tbr", bus.tbr, exp_tbr);
            end
        end
    end

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(input logic [7:0] b);
        bus.data_in = b;
        bus.wrt_tx  = 1'b1;
        @(negedge clk);
        bus.wrt_tx  = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        bit done;
        done = 1'b0;
        for (int i = 0; i < max_cycles; i++) begin
            if (!m_active && m_q.size() == 0) begin
                done = 1'b1;
                break;
            end
            @(negedge clk);
        end
        if (!done)
            check("drain_timeout", 0, 1);
        adv(3);
    endtask

    initial begin
        rst         = 1'b1;
        enable      = 1'b0;
        bus.wrt_tx  = 1'b0;
        bus.data_in = '0;
        adv(2);
        check("reset_txd", txd, 1);
        check("reset_tbr", bus.tbr, 1);
        rst    = 1'b0;
        chk_en = 1'b1;

        // 1: idle line stays high and ready
        adv(1000);
        check("idle_txd", txd, 1);
        check("idle_tbr", bus.tbr, 1);

        // 2: 0x55 at one tick per clk; k = clks after the write edge
        enable = 1'b1;
        write_byte(8'h55);
        adv(1);   check("w55_k1_idle",   txd, 1);
        adv(1);   check("w55_k2_start",  txd, 0);
        adv(15);  check("w55_k17_start", txd, 0);
        adv(1);   check("w55_k18_d0",    txd, 1);
        adv(16);  check("w55_k34_d1",    txd, 0);
        adv(111); check("w55_k145_d7",   txd, 0);
        adv(1);   check("w55_k146_stop", txd, 1);
        drain(500);

        // 3: fill the FIFO with the baud tick stopped
        enable = 1'b0;
        write_byte(8'h01);
        write_byte(8'h02);
        write_byte(8'h03);
        write_byte(8'h04);
        check("fill4_tbr",   bus.tbr, 1);
        check("fill4_start", txd, 0);
        write_byte(8'h05);
        check("fill5_tbr", bus.tbr, 0);
        write_byte(8'h06);
        check("drop6_tbr", bus.tbr, 0);
        enable = 1'b1;
        adv(160); check("full_until_pop", bus.tbr, 0);
        adv(1);   check("pop_frees_slot", bus.tbr, 1);
        drain(2000);

        // 4: back-to-back frames, one idle clk between stop and start
        write_byte(8'hA5);
        write_byte(8'h5A);
        adv(160); check("b2b_k161_stop", txd, 1);
        adv(1);   check("b2b_k162_gap",  txd, 1);
        adv(1);   check("b2b_k163_start", txd, 0);
        drain(1000);

        // 5: reset during data bit 3 of 0xA3 (bit 3 = 0)
        write_byte(8'hA3);
        adv(70);
        check("pre_rst_d3", txd, 0);
        rst = 1'b1;
        #1;
        check("rst_mid_txd", txd, 1);
        check("rst_mid_tbr", bus.tbr, 1);
        @(negedge clk);
        rst = 1'b0;
        write_byte(8'h3C);
        adv(1);  check("post_rst_k1", txd, 1);
        adv(1);  check("post_rst_k2", txd, 0);
        adv(32); check("post_rst_k34_d1", txd, 0);
        adv(16); check("post_rst_k50_d2", txd, 1);
        drain(500);

`ifdef SPART_TX_PARITY_EN
        // 6: even parity bit sits between data and stop
        write_byte(8'h07);
        adv(146); check("par07_k146", txd, 1);
        adv(16);  check("par07_k162_stop", txd, 1);
        drain(500);
        write_byte(8'h03);
        adv(146); check("par03_k146", txd, 0);
        adv(16);  check("par03_k162_stop", txd, 1);
        drain(500);
`endif

        chk_en = 1'b0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
